// File: rtl/ucst_limiter_pkg.sv
// Shared types for the uncached-store limiter: FSM state encoding and stats counter width.
package ucst_limiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY,
    FULL,
    DRAIN,
    DONE
  } ucst_state_e;

  localparam int unsigned UCST_STALL_CNT_W = 32;

endpackage

// File: rtl/ucst_credit_counter.sv
// Up/down count of issued-but-unacknowledged uncached stores, with a sticky underflow flag.
module ucst_credit_counter #(
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic [CntWidth-1:0] cnt_next_o,
  output logic                underflow_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                underflow_q, underflow_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    if (dec_i && (cnt_q == '0)) begin
      underflow_d = 1'b1;
    end
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign cnt_next_o  = cnt_d;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/uncached_store_limiter.sv
// Credit gate for uncached stores with fence drain; optional stall statistics when
// UCST_LIMITER_STATS_EN is defined (adds stall_cycles_o).
module uncached_store_limiter
  import ucst_limiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  input  logic                req_uncached_i,
  output logic                req_ready_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  input  logic                bresp_valid_i,
  input  logic                fence_i,
  output logic                fence_done_o,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                err_o
`ifdef UCST_LIMITER_STATS_EN
  ,
  output logic [UCST_STALL_CNT_W-1:0] stall_cycles_o
`endif
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  ucst_state_e         state_q;
  ucst_state_e         level_state;
  logic                fence_done_q;
  logic [CntWidth-1:0] cnt;
  logic [CntWidth-1:0] cnt_next;
  logic                allow;
  logic                issue;

  // DONE still stalls so nothing slips in between the drain and the done pulse.
  assign allow = (state_q != DRAIN) && (state_q != DONE) &&
                 (!req_uncached_i || (cnt < CntMax));

  assign out_valid_o = req_valid_i && allow;
  assign req_ready_o = out_ready_i && allow;
  assign issue       = out_valid_o && out_ready_i && req_uncached_i;

  ucst_credit_counter #(
    .MaxOutstanding(MaxOutstanding),
    .CntWidth      (CntWidth)
  ) u_credit_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (issue),
    .dec_i      (bresp_valid_i),
    .cnt_o      (cnt),
    .cnt_next_o (cnt_next),
    .underflow_o(err_o)
  );

  always_comb begin
    level_state = BUSY;
    if (cnt_next == '0) begin
      level_state = IDLE;
    end else if (cnt_next == CntMax) begin
      level_state = FULL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fence_done_q <= 1'b0;
    end else begin
      fence_done_q <= 1'b0;
      case (state_q)
        IDLE, BUSY, FULL: begin
          if (fence_i) begin
            // A same-cycle issue can leave stores in flight even from IDLE.
            if (cnt_next == '0) begin
              state_q      <= DONE;
              fence_done_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            state_q <= level_state;
          end
        end
        DRAIN: begin
          if (cnt_next == '0) begin
            state_q      <= DONE;
            fence_done_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fence_done_o  = fence_done_q;
  assign outstanding_o = cnt;

`ifdef UCST_LIMITER_STATS_EN
  logic [UCST_STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (req_valid_i && !allow && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + UCST_STALL_CNT_W'(1);
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  a_no_issue_at_max: assert property (@(posedge clk_i) disable iff (rst_i)
    !(issue && (cnt == CntMax)));

  a_done_single_cycle: assert property (@(posedge clk_i) disable iff (rst_i)
    fence_done_q |=> !fence_done_q);
`endif

endmodule

// File: tb/tb_uncached_store_limiter.sv
// Directed self-checking bench for uncached_store_limiter (MaxOutstanding = 7).
module tb_uncached_store_limiter;

  localparam int unsigned Max = 7;
  localparam int unsigned Cw  = $clog2(Max + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_uncached_i;
  logic          req_ready_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          bresp_valid_i;
  logic          fence_i;
  logic          fence_done_o;
  logic [Cw-1:0] outstanding_o;
  logic          err_o;
`ifdef UCST_LIMITER_STATS_EN
  logic [31:0]   stall_cycles_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  uncached_store_limiter #(
    .MaxOutstanding(Max)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_uncached_i(req_uncached_i),
    .req_ready_o   (req_ready_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .bresp_valid_i (bresp_valid_i),
    .fence_i       (fence_i),
    .fence_done_o  (fence_done_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
`ifdef UCST_LIMITER_STATS_EN
    ,
    .stall_cycles_o(stall_cycles_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i          = 1'b1;
    req_valid_i    = 1'b0;
    req_uncached_i = 1'b0;
    out_ready_i    = 1'b1;
    bresp_valid_i  = 1'b0;
    fence_i        = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check_eq("reset_cnt", 32'(outstanding_o), 0);
    check_eq("reset_err", 32'(err_o), 0);
    check_eq("reset_done", 32'(fence_done_o), 0);

    // T1: fill to the limit, then one ack frees a slot
    req_valid_i    = 1'b1;
    req_uncached_i = 1'b1;
    for (int i = 0; i < int'(Max); i++) begin
      #1;
      check_eq($sformatf("t1_ready_%0d", i), 32'(req_ready_o), 1);
      tick();
    end
    #1;
    check_eq("t1_cnt_full", 32'(outstanding_o), 7);
    check_eq("t1_8th_ready", 32'(req_ready_o), 0);
    check_eq("t1_8th_valid", 32'(out_valid_o), 0);
    bresp_valid_i = 1'b1;
    #1;
    check_eq("t1_ack_cycle_ready", 32'(req_ready_o), 0);
    tick();
    bresp_valid_i = 1'b0;
    #1;
    check_eq("t1_after_ack_cnt", 32'(outstanding_o), 6);
    check_eq("t1_8th_accepted", 32'(req_ready_o), 1);
    tick();
    req_uncached_i = 1'b0;
    #1;
    check_eq("t1_refill_cnt", 32'(outstanding_o), 7);
    check_eq("t1_cached_in_full", 32'(req_ready_o), 1);
    check_eq("t1_cached_valid", 32'(out_valid_o), 1);
    tick();
    check_eq("t1_cached_no_count", 32'(outstanding_o), 7);

    // Drain down to 3
    req_valid_i   = 1'b0;
    bresp_valid_i = 1'b1;
    repeat (4) tick();
    bresp_valid_i = 1'b0;
    #1;
    check_eq("t2_pre_cnt", 32'(outstanding_o), 3);

    // T2: issue and ack together leave the count unchanged
    req_valid_i    = 1'b1;
    req_uncached_i = 1'b1;
    bresp_valid_i  = 1'b1;
    #1;
    check_eq("t2_ready", 32'(req_ready_o), 1);
    tick();
    req_valid_i   = 1'b0;
    bresp_valid_i = 1'b0;
    #1;
    check_eq("t2_cnt_same", 32'(outstanding_o), 3);
    req_valid_i = 1'b1;
    out_ready_i = 1'b0;
    #1;
    check_eq("t2_nordy_valid", 32'(out_valid_o), 1);
    check_eq("t2_nordy_ready", 32'(req_ready_o), 0);
    tick();
    check_eq("t2_nordy_cnt", 32'(outstanding_o), 3);
    req_valid_i   = 1'b0;
    out_ready_i   = 1'b1;
    bresp_valid_i = 1'b1;
    tick();
    bresp_valid_i = 1'b0;

    // T3: fence at cnt=2
    fence_i = 1'b1;
    tick();
    fence_i        = 1'b0;
    req_valid_i    = 1'b1;
    req_uncached_i = 1'b0;
    #1;
    check_eq("t3_cnt", 32'(outstanding_o), 2);
    check_eq("t3_drain_ready", 32'(req_ready_o), 0);
    check_eq("t3_drain_valid", 32'(out_valid_o), 0);
    bresp_valid_i = 1'b1;
    tick();
    check_eq("t3_done_early", 32'(fence_done_o), 0);
    check_eq("t3_cnt1", 32'(outstanding_o), 1);
    tick();
    bresp_valid_i = 1'b0;
    #1;
    check_eq("t3_done_pulse", 32'(fence_done_o), 1);
    check_eq("t3_done_stall", 32'(req_ready_o), 0);
    check_eq("t3_cnt0", 32'(outstanding_o), 0);
    tick();
    check_eq("t3_done_low", 32'(fence_done_o), 0);
    check_eq("t3_idle_ready", 32'(req_ready_o), 1);
    req_valid_i = 1'b0;

    // T4: fence with nothing outstanding, then fence coinciding with the last ack
    fence_i = 1'b1;
    tick();
    fence_i = 1'b0;
    #1;
    check_eq("t4_idle_done", 32'(fence_done_o), 1);
    tick();
    check_eq("t4_idle_done_low", 32'(fence_done_o), 0);
    req_valid_i    = 1'b1;
    req_uncached_i = 1'b1;
    tick();
    req_valid_i   = 1'b0;
    fence_i       = 1'b1;
    bresp_valid_i = 1'b1;
    tick();
    fence_i       = 1'b0;
    bresp_valid_i = 1'b0;
    #1;
    check_eq("t4_last_ack_done", 32'(fence_done_o), 1);
    check_eq("t4_last_ack_cnt", 32'(outstanding_o), 0);
    tick();
    check_eq("t4_last_ack_done_low", 32'(fence_done_o), 0);

    // T5: spurious ack sets the sticky error; reset mid-drain
    bresp_valid_i = 1'b1;
    tick();
    bresp_valid_i = 1'b0;
    #1;
    check_eq("t5_err_set", 32'(err_o), 1);
    check_eq("t5_err_cnt", 32'(outstanding_o), 0);
    repeat (3) tick();
    check_eq("t5_err_sticky", 32'(err_o), 1);
    req_valid_i    = 1'b1;
    req_uncached_i = 1'b1;
    repeat (2) tick();
    req_valid_i = 1'b0;
    fence_i     = 1'b1;
    tick();
    fence_i = 1'b0;
    #1;
    check_eq("t5_drain_cnt", 32'(outstanding_o), 2);
    rst_i = 1'b1;
    tick();
    check_eq("t5_rst_cnt", 32'(outstanding_o), 0);
    check_eq("t5_rst_err", 32'(err_o), 0);
    check_eq("t5_rst_done", 32'(fence_done_o), 0);
    rst_i = 1'b0;
    tick();
    check_eq("t5_no_done_after_rst", 32'(fence_done_o), 0);
    req_valid_i = 1'b1;
    #1;
    check_eq("t5_idle_after_rst", 32'(req_ready_o), 1);
    req_valid_i = 1'b0;

`ifdef UCST_LIMITER_STATS_EN
    // T6: ten stalled cycles during a drain
    #1;
    check_eq("t6_stats_zero", stall_cycles_o, 0);
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    fence_i     = 1'b1;
    tick();
    fence_i     = 1'b0;
    req_valid_i = 1'b1;
    repeat (10) tick();
    req_valid_i = 1'b0;
    #1;
    check_eq("t6_stall_10", stall_cycles_o, 10);
    bresp_valid_i = 1'b1;
    tick();
    bresp_valid_i = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
